// File: rtl/lzw_decoder_if.sv
// -----------------------------------------------------------------------------
// lzw_decoder_if
// Stream interface for the LZW decoder: a code stream into the decoder and a
// byte stream out of it, each with a valid/ready handshake.
//
//   in_code   : code presented to the decoder
//   in_valid  : in_code is valid
//   in_last   : in_code is the last code of its stream (qualified by in_valid)
//   in_ready  : decoder takes the code this cycle
//   out_byte  : decoded byte
//   out_valid : out_byte is valid
//   out_last  : out_byte is the final byte of a stream
//   out_ready : sink takes the byte this cycle
//
// master = code source / byte sink, slave = decoder.
// -----------------------------------------------------------------------------
interface lzw_decoder_if #(
    parameter int CODE_WIDTH = 12,
    parameter int CHAR_WIDTH = 8
);
    logic [CODE_WIDTH-1:0] in_code;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [CHAR_WIDTH-1:0] out_byte;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output in_code, in_valid, in_last, out_ready,
        input  in_ready, out_byte, out_valid, out_last
    );

    modport slave (
        input  in_code, in_valid, in_last, out_ready,
        output in_ready, out_byte, out_valid, out_last
    );
endinterface

// File: rtl/lzw_decoder.sv
// -----------------------------------------------------------------------------
// lzw_decoder
// LZW decompressor. Rebuilds the dictionary in step with the encoder (entries
// FIRST_CODE..DEPTH-1, each {prefix code, last char}) in a synchronous RAM, and
// walks each code's prefix chain into a LIFO stack so bytes come out forward.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : lzw_decoder_if.slave (code in, byte out)
//   dict_full : dictionary has no free entry (next_code == DEPTH), registered
//   err       : sticky, set when an undecodable code was received
// -----------------------------------------------------------------------------
module lzw_decoder #(
    parameter int CODE_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int CHAR_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    lzw_decoder_if.slave bus,
    output logic         dict_full,
    output logic         err
);
    localparam int ENTRY_W = CODE_WIDTH + CHAR_WIDTH;
    localparam logic [CODE_WIDTH:0] FIRST_CODE = (CODE_WIDTH+1)'(1 << CHAR_WIDTH);
    localparam logic [CODE_WIDTH:0] DICT_END   = (CODE_WIDTH+1)'(DEPTH);
    localparam logic [CODE_WIDTH:0] ONE        = (CODE_WIDTH+1)'(1);

    typedef enum logic [2:0] {IDLE, RD, PUSH, LIT, EMIT, UPD} state_t;

    state_t                state_q, state_d;
    logic [CODE_WIDTH:0]   next_code_q, next_code_d;
    logic [CODE_WIDTH-1:0] prev_code_q, prev_code_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [CHAR_WIDTH-1:0] prev_first_char_q, prev_first_char_d;
    logic [CODE_WIDTH-1:0] cur_q, cur_d;
    logic [CHAR_WIDTH-1:0] first_char_q, first_char_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;      // code accepted in IDLE, becomes prev in UPD
    logic [CODE_WIDTH:0]   sp_q, sp_d;
    logic                  last_pending_q, last_pending_d;
    logic                  err_q, err_d;
    logic                  dict_full_q, dict_full_d;

    logic [ENTRY_W-1:0]    dict_mem [DEPTH];
    logic [ENTRY_W-1:0]    dict_rdata_q;
    logic [CHAR_WIDTH-1:0] stack_mem [DEPTH];

    logic                  dict_we;
    logic                  dict_re;
    logic                  stack_we;
    logic [CHAR_WIDTH-1:0] stack_wdata;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_last;
    logic [CHAR_WIDTH-1:0] out_byte;

    logic [CODE_WIDTH-1:0] entry_prefix;
    logic [CHAR_WIDTH-1:0] entry_char;
    logic [CODE_WIDTH-1:0] top_idx;

    assign entry_prefix = dict_rdata_q[ENTRY_W-1:CHAR_WIDTH];
    assign entry_char   = dict_rdata_q[CHAR_WIDTH-1:0];
    assign top_idx      = sp_q[CODE_WIDTH-1:0] - CODE_WIDTH'(1);

    // Codes below FIRST_CODE are single bytes and terminate a chain walk.
    function automatic logic is_literal(input logic [CODE_WIDTH-1:0] c);
        return c[CODE_WIDTH-1:CHAR_WIDTH] == '0;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d           = state_q;
        next_code_d       = next_code_q;
        prev_code_d       = prev_code_q;
        prev_valid_d      = prev_valid_q;
        prev_first_char_d = prev_first_char_q;
        cur_d             = cur_q;
        first_char_d      = first_char_q;
        code_d            = code_q;
        sp_d              = sp_q;
        last_pending_d    = last_pending_q;
        err_d             = err_q;
        dict_we           = 1'b0;
        dict_re           = 1'b0;
        stack_we          = 1'b0;
        stack_wdata       = '0;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        out_last          = 1'b0;
        out_byte          = '0;

        unique case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (bus.in_valid && in_ready) begin
                    last_pending_d = bus.in_last;
                    code_d         = bus.in_code;
                    if (is_literal(bus.in_code)) begin
                        cur_d   = bus.in_code;
                        state_d = LIT;
                    end else if ({1'b0, bus.in_code} < next_code_q) begin
                        cur_d   = bus.in_code;
                        state_d = RD;
                    end else if ({1'b0, bus.in_code} == next_code_q && prev_valid_q) begin
                        // KwKwK: the entry is not in the dictionary yet; it is
                        // prev string + its own first char, so push that char
                        // first and walk the previous code.
                        stack_we    = 1'b1;
                        stack_wdata = prev_first_char_q;
                        sp_d        = sp_q + ONE;
                        cur_d       = prev_code_q;
                        state_d     = is_literal(prev_code_q) ? LIT : RD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD: begin
                dict_re = 1'b1;
                state_d = PUSH;
            end
            PUSH: begin
                stack_we    = 1'b1;
                stack_wdata = entry_char;
                sp_d        = sp_q + ONE;
                cur_d       = entry_prefix;
                state_d     = is_literal(entry_prefix) ? LIT : RD;
            end
            LIT: begin
                stack_we     = 1'b1;
                stack_wdata  = cur_q[CHAR_WIDTH-1:0];
                sp_d         = sp_q + ONE;
                first_char_d = cur_q[CHAR_WIDTH-1:0];
                state_d      = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_byte  = stack_mem[top_idx];
                out_last  = (sp_q == ONE) && last_pending_q;
                if (bus.out_ready) begin
                    sp_d = sp_q - ONE;
                    if (sp_q == ONE) begin
                        state_d = UPD;
                    end
                end
            end
            UPD: begin
                if (prev_valid_q && next_code_q < DICT_END) begin
                    dict_we     = 1'b1;
                    next_code_d = next_code_q + ONE;
                end
                prev_code_d       = code_q;
                prev_first_char_d = first_char_q;
                prev_valid_d      = 1'b1;
                if (last_pending_q) begin
                    next_code_d  = FIRST_CODE;
                    prev_valid_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        dict_full_d = (next_code_d == DICT_END);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            next_code_q       <= FIRST_CODE;
            prev_code_q       <= '0;
            prev_valid_q      <= 1'b0;
            prev_first_char_q <= '0;
            cur_q             <= '0;
            first_char_q      <= '0;
            code_q            <= '0;
            sp_q              <= '0;
            last_pending_q    <= 1'b0;
            err_q             <= 1'b0;
            dict_full_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            next_code_q       <= next_code_d;
            prev_code_q       <= prev_code_d;
            prev_valid_q      <= prev_valid_d;
            prev_first_char_q <= prev_first_char_d;
            cur_q             <= cur_d;
            first_char_q      <= first_char_d;
            code_q            <= code_d;
            sp_q              <= sp_d;
            last_pending_q    <= last_pending_d;
            err_q             <= err_d;
            dict_full_q       <= dict_full_d;
        end
    end

    // NOTE: the dictionary and stack RAMs are deliberately not reset; next_code
    // and sp define which locations hold live data, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (dict_we) begin
            dict_mem[next_code_q[CODE_WIDTH-1:0]] <= {prev_code_q, first_char_q};
        end
        if (dict_re) begin
            dict_rdata_q <= dict_mem[cur_q];
        end
        if (stack_we) begin
            stack_mem[sp_q[CODE_WIDTH-1:0]] <= stack_wdata;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_byte  = out_byte;
    assign dict_full     = dict_full_q;
    assign err           = err_q;
endmodule

// File: tb/tb_lzw_decoder.sv
// -----------------------------------------------------------------------------
// tb_lzw_decoder
// Self-checking bench for lzw_decoder. A string-level LZW reference model
// (dictionary of byte queues) predicts the bytes, out_last, first-byte latency,
// err and dict_full for every code; directed streams cover the documented
// cases, then a randomized stream with random out_ready back-pressure.
// -----------------------------------------------------------------------------
module tb_lzw_decoder;
    localparam int CW    = 12;
    localparam int CHW   = 8;
    localparam int DEPTH = 4096;

    typedef logic [7:0] str_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dict_full;
    logic err;

    lzw_decoder_if #(.CODE_WIDTH(CW), .CHAR_WIDTH(CHW)) bus ();

    lzw_decoder #(
        .CODE_WIDTH(CW),
        .DEPTH     (DEPTH),
        .CHAR_WIDTH(CHW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dict_full(dict_full),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: strings, not prefix links.
    str_t m_dict [DEPTH];
    int   m_next;
    bit   m_prev_valid;
    str_t m_prev;
    bit   m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next       = 256;
        m_prev_valid = 1'b0;
        m_prev.delete();
        m_err        = 1'b0;
    endtask

    // Decode one code at string level; returns the expected byte string and the
    // accept-to-first-byte latency (2 per dictionary link plus 2).
    task automatic model_step(input int code, input bit last, output bit ok,
                              output str_t s, output int exp_lat);
        str_t tmp;
        ok = 1'b1;
        s.delete();
        exp_lat = 0;
        if (code < 256) begin
            s.push_back(code[7:0]);
            exp_lat = 2;
        end else if (code < m_next) begin
            s = m_dict[code];
            exp_lat = 2 * s.size();
        end else if (code == m_next && m_prev_valid) begin
            s = m_prev;
            s.push_back(m_prev[0]);
            exp_lat = 2 * s.size() - 2;
        end else begin
            ok    = 1'b0;
            m_err = 1'b1;
            return;
        end
        if (m_prev_valid && m_next < DEPTH) begin
            tmp = m_prev;
            tmp.push_back(s[0]);
            m_dict[m_next] = tmp;
            m_next++;
        end
        m_prev       = s;
        m_prev_valid = 1'b1;
        if (last) begin
            m_next       = 256;
            m_prev_valid = 1'b0;
        end
    endtask

    // All tasks start and return at posedge + 1.
    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_byte",  32'(bus.out_byte),  32'd0);
        check("rst_dict_full", 32'(dict_full),     32'd0);
        check("rst_err",       32'(err),           32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input int code, input bit last);
        int w;
        w = 0;
        bus.in_code  = code[CW-1:0];
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
            @(negedge clk);
        end
        check("accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_code  = CW'($urandom);
    endtask

    // mode 0: out_ready always 1; 1: toggles 1/0 each cycle; 2: random.
    task automatic collect(input str_t s, input bit last, input int exp_lat, input int mode);
        int n, budget, lat, got, cyc, gap;
        bit seen, stalled, extra;
        logic [7:0] held_b;
        logic held_l;
        n = s.size();
        budget = 8 * n + 100;
        lat = 0; got = 0; cyc = 0; gap = 0;
        seen = 1'b0; stalled = 1'b0; extra = 1'b0;
        held_b = '0; held_l = 1'b0;
        while (got < n && cyc < budget) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 2 == 0);
                default: bus.out_ready = ($urandom_range(3, 0) != 0);
            endcase
            lat++;
            @(negedge clk);
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("first_out_latency", 32'(lat), 32'(exp_lat));
                end
                if (stalled) begin
                    check("stall_byte_stable", 32'(bus.out_byte), 32'(held_b));
                    check("stall_last_stable", 32'(bus.out_last), 32'(held_l));
                end
                check("out_byte", 32'(bus.out_byte), 32'(s[got]));
                check("out_last", 32'(bus.out_last), 32'(last && got == n - 1));
                if (bus.out_ready) begin
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_b  = bus.out_byte;
                    held_l  = bus.out_last;
                end
            end else if (seen) begin
                check("out_valid_held", 32'(bus.out_valid), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("byte_count", 32'(got), 32'(n));
        bus.out_ready = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && gap < 20) begin
            if (bus.out_valid) extra = 1'b1;
            @(posedge clk); #1;
            gap++;
            @(negedge clk);
        end
        if (bus.out_valid) extra = 1'b1;
        check("pop_to_in_ready_gap", 32'(gap), 32'd1);
        check("no_extra_byte", 32'(extra), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_code(input int code, input bit last, input int mode);
        bit ok, bad_v, bad_r;
        str_t s;
        int exp_lat;
        model_step(code, last, ok, s, exp_lat);
        send(code, last);
        if (!ok) begin
            bad_v = 1'b0;
            bad_r = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.out_valid) bad_v = 1'b1;
                if (!bus.in_ready) bad_r = 1'b1;
                @(posedge clk); #1;
            end
            check("bad_code_no_output", 32'(bad_v), 32'd0);
            check("bad_code_in_ready",  32'(bad_r), 32'd0);
        end else begin
            collect(s, last, exp_lat, mode);
        end
        @(negedge clk);
        check("err_flag",  32'(err),       32'(m_err));
        check("dict_full", 32'(dict_full), 32'(m_next == DEPTH));
        @(posedge clk); #1;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, code, r;
        bit last, bad_v;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // "ABABABA" stream; afterwards 0x100 is undefined again, literals still decode.
        run_code(12'h041, 1'b0, 0);
        run_code(12'h042, 1'b0, 0);
        run_code(12'h100, 1'b0, 0);
        run_code(12'h102, 1'b1, 0);
        run_code(12'h100, 1'b0, 0);
        run_code(12'h041, 1'b0, 0);

        // Same stream under a 1/0 out_ready pattern.
        do_reset();
        run_code(12'h041, 1'b0, 1);
        run_code(12'h042, 1'b0, 1);
        run_code(12'h100, 1'b0, 1);
        run_code(12'h102, 1'b1, 1);

        // Undefined code straight after reset, then a literal with err sticky.
        do_reset();
        run_code(12'h100, 1'b0, 0);
        run_code(12'h041, 1'b0, 0);

        // KwKwK with a literal prefix.
        do_reset();
        run_code(12'h041, 1'b0, 0);
        run_code(12'h100, 1'b0, 0);

        // Reset while EMIT holds two bytes under back-pressure.
        do_reset();
        run_code(12'h041, 1'b0, 0);
        run_code(12'h042, 1'b0, 0);
        bus.out_ready = 1'b0;
        send(12'h100, 1'b0);
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
            @(negedge clk);
        end
        check("emit_reached", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_emit_out_valid", 32'(bus.out_valid), 32'd0);
        bad_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.out_valid) bad_v = 1'b1;
        end
        check("rst_mid_emit_no_bytes", 32'(bad_v), 32'd0);
        @(posedge clk); #1;
        run_code(12'h100, 1'b0, 0);

        // Fill the dictionary, decode the top entry, then release it with in_last.
        do_reset();
        for (int i = 0; i < 3841 && n_fail < 20; i++) begin
            run_code(12'h041, 1'b0, 0);
        end
        run_code(12'hFFF, 1'b0, 0);
        run_code(12'h042, 1'b0, 0);
        run_code(12'h800, 1'b0, 2);
        run_code(12'h041, 1'b1, 0);
        run_code(12'h100, 1'b0, 0);

        // Randomized stream with random back-pressure.
        do_reset();
        for (int i = 0; i < 300 && n_fail < 20; i++) begin
            r = $urandom_range(99, 0);
            if (r < 3 && m_next < DEPTH - 1) begin
                code = $urandom_range(DEPTH - 1, m_next + 1);
            end else if (r < 15 && m_prev_valid && m_next < DEPTH) begin
                code = m_next;
            end else if (r < 45 || m_next == 256) begin
                code = $urandom_range(255, 0);
            end else begin
                code = $urandom_range(m_next - 1, 256);
            end
            last = ($urandom_range(24, 0) == 0);
            run_code(code, last, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
